// File: rtl/xeng_pkg.sv
// -----------------------------------------------------------------------------
// xeng_pkg
// Shared helpers for the X-engine tap family.
//   clog2           ceil(log2(value)), 0 for value <= 1
//   acc_w/out_w/in_w  derived bus widths of a tap
//   stokes_re_lsb / stokes_im_lsb
//                   LSB of the real/imag word of Stokes product s on the
//                   accumulation chain (s = 0 at the MSB, real above imag)
//   sample_lsb      LSB of the (pol, lane) complex sample on an antenna bus
//                   (pol-major with pol 0 at the MSB, lane-minor, real above imag)
// -----------------------------------------------------------------------------
package xeng_pkg;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 32'sd1;
    end
    return result;
  endfunction

  function automatic int acc_w(input int bitwidth, input int p_bits, input int sal_bits);
    return 32'sd2 * bitwidth + 32'sd1 + p_bits + sal_bits;
  endfunction

  function automatic int out_w(input int n_pol, input int accw);
    return n_pol * n_pol * 32'sd2 * accw;
  endfunction

  function automatic int in_w(input int bitwidth, input int n_pol, input int p_bits);
    return 32'sd2 * bitwidth * n_pol * (32'sd1 <<< p_bits);
  endfunction

  function automatic int stokes_re_lsb(input int s, input int n_pol, input int accw);
    return ((n_pol * n_pol - 32'sd1 - s) * 32'sd2 + 32'sd1) * accw;
  endfunction

  function automatic int stokes_im_lsb(input int s, input int n_pol, input int accw);
    return (n_pol * n_pol - 32'sd1 - s) * 32'sd2 * accw;
  endfunction

  function automatic int sample_lsb(input int pol, input int lane, input int n_pol,
                                    input int p, input int bitwidth);
    return ((n_pol * p - 32'sd1) - (pol * p + lane)) * 32'sd2 * bitwidth;
  endfunction

endpackage

// File: rtl/xeng_tap_delay.sv
// -----------------------------------------------------------------------------
// xeng_tap_delay
// Fixed delay of DELAY cycles built as a ring buffer with a registered read,
// so the storage maps onto block RAM. Only the pointers are reset; a fill flag
// forces the output to zero until every entry has been written since reset.
//   clk    in   clock
//   rst_n  in   synchronous active-low reset
//   din    in   WIDTH  data in
//   dout   out  WIDTH  din delayed DELAY cycles
// -----------------------------------------------------------------------------
module xeng_tap_delay
  import xeng_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DELAY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DELAY > 1) begin : g_ring
    // The read register supplies one cycle, the ring supplies the rest.
    localparam int DEPTH = DELAY - 1;
    localparam int PTR_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_q;
    logic             rd_vld_q;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             filled_q, filled_d;

    // Pointer advance and fill tracking
    always_comb begin
      ptr_d    = ptr_q;
      filled_d = filled_q;
      if (ptr_q == PTR_LAST) begin
        ptr_d    = '0;
        filled_d = 1'b1;
      end else begin
        ptr_d    = ptr_q + PTR_W'(1);
        filled_d = filled_q;
      end
    end

    // Read-before-write RAM port, no reset on the storage
    always_ff @(posedge clk) begin
      mem_q[ptr_q] <= din;
      rd_q         <= mem_q[ptr_q];
    end

    // Pointer, fill flag and read-valid registers
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ptr_q    <= '0;
        filled_q <= 1'b0;
        rd_vld_q <= 1'b0;
      end else begin
        ptr_q    <= ptr_d;
        filled_q <= filled_d;
        rd_vld_q <= filled_q;
      end
    end

    assign dout = rd_vld_q ? rd_q : '0;
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q;

    // Single-cycle delay degenerates to one register
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else begin
        dout_q <= din;
      end
    end

    assign dout = dout_q;
  end

endmodule

// File: rtl/xeng_baseline_tap_gen.sv
// -----------------------------------------------------------------------------
// xeng_baseline_tap_gen
// One cell of the X-engine systolic antenna chain. Delays the "delayed"
// antenna by one accumulation window, picks the partner antenna from the
// last-triangle or non-delayed stream by tap separation, complex-multiply-
// accumulates all pol products over P lanes and SAL cycles, and drops each
// finished window onto the shared accumulation chain.
//   clk, rst_n                  clock, synchronous active-low reset
//   sync_in / sync_out          window alignment pulse in / registered out
//   tap_sep                     tap separation, latched on sync_in
//   a_del, a_ndel, a_end        antenna streams in
//   a_del_out                   a_del delayed SAL+1 cycles
//   a_ndel_out, a_end_out       1-cycle passthroughs
//   rst_n_out                   registered reset for the next tap
//   acc_in / acc_valid_in       accumulation chain in
//   acc_out / acc_valid_out     accumulation chain out
//   err_collision               sticky: chain data arrived on a dump cycle
// -----------------------------------------------------------------------------
module xeng_baseline_tap_gen
  import xeng_pkg::*;
#(
  parameter  int BITWIDTH            = 4,
  parameter  int N_POL               = 2,
  parameter  int P_FACTOR_BITS       = 0,
  parameter  int SERIAL_ACC_LEN_BITS = 7,
  parameter  int N_ANTS              = 8,
  parameter  int TAP_SEP_DEFAULT     = 1,
  localparam int IN_W     = in_w(BITWIDTH, N_POL, P_FACTOR_BITS),
  localparam int ACC_W    = acc_w(BITWIDTH, P_FACTOR_BITS, SERIAL_ACC_LEN_BITS),
  localparam int OUT_W    = out_w(N_POL, ACC_W),
  localparam int ANT_BITS = clog2(N_ANTS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sync_in,
  input  logic [ANT_BITS-1:0] tap_sep,
  input  logic [IN_W-1:0]     a_del,
  input  logic [IN_W-1:0]     a_ndel,
  input  logic [IN_W-1:0]     a_end,
  input  logic [OUT_W-1:0]    acc_in,
  input  logic                acc_valid_in,
  output logic [IN_W-1:0]     a_del_out,
  output logic [IN_W-1:0]     a_ndel_out,
  output logic [IN_W-1:0]     a_end_out,
  output logic                sync_out,
  output logic                rst_n_out,
  output logic [OUT_W-1:0]    acc_out,
  output logic                acc_valid_out,
  output logic                err_collision
);

  localparam int P        = 1 << P_FACTOR_BITS;
  localparam int SAL      = 1 << SERIAL_ACC_LEN_BITS;
  localparam int CTR_W    = ANT_BITS + SERIAL_ACC_LEN_BITS;
  localparam int N_STOKES = N_POL * N_POL;
  localparam int PROD_W   = 2 * BITWIDTH + 1;
  localparam logic [CTR_W-1:0] SAL_MASK = CTR_W'(SAL - 1);

  // Delay line and passthroughs
  logic [IN_W-1:0] a_dly_s;
  logic [IN_W-1:0] a_del_out_q, a_ndel_out_q, a_end_out_q;
  logic            sync_out_q, rst_n_out_q;

  // Mux counter and control
  logic [CTR_W-1:0]    mux_ctr_q, mux_ctr_d;
  logic [ANT_BITS-1:0] tap_sep_q, tap_sep_d;
  logic                armed_q, armed_d;
  logic                use_end_s, first_s, last_s;

  // Operand stage
  logic [IN_W-1:0] op_a_q, op_b_q, op_b_d;
  logic            op_vld_q, op_first_q, op_last_q;

  // Product stage
  logic signed [ACC_W-1:0] prod_re_q [N_STOKES];
  logic signed [ACC_W-1:0] prod_im_q [N_STOKES];
  logic signed [ACC_W-1:0] prod_re_d [N_STOKES];
  logic signed [ACC_W-1:0] prod_im_d [N_STOKES];
  logic                    pr_vld_q, pr_first_q, pr_last_q;
  logic signed [PROD_W-1:0] ar_s, ai_s, br_s, bi_s, re_s, im_s;

  // Accumulator stage
  logic signed [ACC_W-1:0] acc_re_q [N_STOKES];
  logic signed [ACC_W-1:0] acc_im_q [N_STOKES];
  logic signed [ACC_W-1:0] acc_re_d [N_STOKES];
  logic signed [ACC_W-1:0] acc_im_d [N_STOKES];
  logic                    acc_done_q, acc_done_d;

  // Chain output stage
  logic [OUT_W-1:0] dump_s;
  logic [OUT_W-1:0] acc_out_q, acc_out_d;
  logic             acc_valid_out_q, acc_valid_out_d;
  logic             err_q, err_d;

  xeng_tap_delay #(
    .WIDTH (IN_W),
    .DELAY (SAL)
  ) u_del (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (a_del),
    .dout  (a_dly_s)
  );

  // Counter, partner select, window tagging and chain output selection
  always_comb begin
    mux_ctr_d = sync_in ? '0 : (mux_ctr_q + CTR_W'(1));
    tap_sep_d = sync_in ? tap_sep : tap_sep_q;
    armed_d   = sync_in | armed_q;
    // mux_ctr < tap_sep_q*SAL, with SAL a power of two
    use_end_s = (mux_ctr_q < (CTR_W'(tap_sep_q) << SERIAL_ACC_LEN_BITS));
    op_b_d    = use_end_s ? a_end : a_ndel;
    first_s   = ((mux_ctr_q & SAL_MASK) == '0);
    last_s    = ((mux_ctr_q & SAL_MASK) == SAL_MASK);

    for (int s = 0; s < N_STOKES; s++) begin
      acc_re_d[s] = acc_re_q[s];
      acc_im_d[s] = acc_im_q[s];
      if (pr_vld_q) begin
        acc_re_d[s] = pr_first_q ? prod_re_q[s] : (acc_re_q[s] + prod_re_q[s]);
        acc_im_d[s] = pr_first_q ? prod_im_q[s] : (acc_im_q[s] + prod_im_q[s]);
      end else begin
        acc_re_d[s] = acc_re_q[s];
        acc_im_d[s] = acc_im_q[s];
      end
    end
    acc_done_d = pr_vld_q & pr_last_q;

    dump_s = '0;
    for (int s = 0; s < N_STOKES; s++) begin
      dump_s[stokes_re_lsb(s, N_POL, ACC_W) +: ACC_W] = acc_re_q[s];
      dump_s[stokes_im_lsb(s, N_POL, ACC_W) +: ACC_W] = acc_im_q[s];
    end

    // A finished window takes the slot; anything arriving alongside is lost
    if (acc_done_q) begin
      acc_out_d       = dump_s;
      acc_valid_out_d = 1'b1;
      err_d           = err_q | acc_valid_in;
    end else begin
      acc_out_d       = acc_in;
      acc_valid_out_d = acc_valid_in;
      err_d           = err_q;
    end
  end

  // Complex multiply a_i*conj(b_j), summed across lanes
  always_comb begin
    ar_s = '0;
    ai_s = '0;
    br_s = '0;
    bi_s = '0;
    re_s = '0;
    im_s = '0;
    for (int s = 0; s < N_STOKES; s++) begin
      prod_re_d[s] = '0;
      prod_im_d[s] = '0;
    end
    for (int i = 0; i < N_POL; i++) begin
      for (int j = 0; j < N_POL; j++) begin
        for (int l = 0; l < P; l++) begin
          ar_s = PROD_W'(signed'(op_a_q[sample_lsb(i, l, N_POL, P, BITWIDTH) + BITWIDTH +: BITWIDTH]));
          ai_s = PROD_W'(signed'(op_a_q[sample_lsb(i, l, N_POL, P, BITWIDTH) +: BITWIDTH]));
          br_s = PROD_W'(signed'(op_b_q[sample_lsb(j, l, N_POL, P, BITWIDTH) + BITWIDTH +: BITWIDTH]));
          bi_s = PROD_W'(signed'(op_b_q[sample_lsb(j, l, N_POL, P, BITWIDTH) +: BITWIDTH]));
          re_s = ar_s * br_s + ai_s * bi_s;
          im_s = ai_s * br_s - ar_s * bi_s;
          prod_re_d[i * N_POL + j] = prod_re_d[i * N_POL + j] + ACC_W'(re_s);
          prod_im_d[i * N_POL + j] = prod_im_d[i * N_POL + j] + ACC_W'(im_s);
        end
      end
    end
  end

  // All state registers, cleared by the synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_del_out_q     <= '0;
      a_ndel_out_q    <= '0;
      a_end_out_q     <= '0;
      sync_out_q      <= 1'b0;
      rst_n_out_q     <= 1'b0;
      mux_ctr_q       <= '0;
      tap_sep_q       <= ANT_BITS'(TAP_SEP_DEFAULT);
      armed_q         <= 1'b0;
      op_a_q          <= '0;
      op_b_q          <= '0;
      op_vld_q        <= 1'b0;
      op_first_q      <= 1'b0;
      op_last_q       <= 1'b0;
      pr_vld_q        <= 1'b0;
      pr_first_q      <= 1'b0;
      pr_last_q       <= 1'b0;
      acc_done_q      <= 1'b0;
      acc_out_q       <= '0;
      acc_valid_out_q <= 1'b0;
      err_q           <= 1'b0;
      for (int s = 0; s < N_STOKES; s++) begin
        prod_re_q[s] <= '0;
        prod_im_q[s] <= '0;
        acc_re_q[s]  <= '0;
        acc_im_q[s]  <= '0;
      end
    end else begin
      a_del_out_q     <= a_dly_s;
      a_ndel_out_q    <= a_ndel;
      a_end_out_q     <= a_end;
      sync_out_q      <= sync_in;
      rst_n_out_q     <= 1'b1;
      mux_ctr_q       <= mux_ctr_d;
      tap_sep_q       <= tap_sep_d;
      armed_q         <= armed_d;
      // The sample taken on the sync edge still belongs to the old window
      op_a_q          <= a_dly_s;
      op_b_q          <= op_b_d;
      op_vld_q        <= armed_q;
      op_first_q      <= first_s;
      op_last_q       <= last_s;
      pr_vld_q        <= op_vld_q;
      pr_first_q      <= op_first_q;
      pr_last_q       <= op_last_q;
      acc_done_q      <= acc_done_d;
      acc_out_q       <= acc_out_d;
      acc_valid_out_q <= acc_valid_out_d;
      err_q           <= err_d;
      for (int s = 0; s < N_STOKES; s++) begin
        prod_re_q[s] <= prod_re_d[s];
        prod_im_q[s] <= prod_im_d[s];
        acc_re_q[s]  <= acc_re_d[s];
        acc_im_q[s]  <= acc_im_d[s];
      end
    end
  end

  assign a_del_out     = a_del_out_q;
  assign a_ndel_out    = a_ndel_out_q;
  assign a_end_out     = a_end_out_q;
  assign sync_out      = sync_out_q;
  assign rst_n_out     = rst_n_out_q;
  assign acc_out       = acc_out_q;
  assign acc_valid_out = acc_valid_out_q;
  assign err_collision = err_q;

endmodule
